// File: rtl/ccpd_sr_responder_pkg.sv
// ccpd_sr_pkg: shared definitions for the CCPD shift-register responder.
//   state_t          - responder FSM states (IDLE / SHIFT / LOAD)
//   SR_BITS_DEFAULT  - default shift-register length (356 bytes x 8)
//   CNT_W            - width of the frame bit counter
package ccpd_sr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } state_t;

   localparam int unsigned SR_BITS_DEFAULT = 2848;
   localparam int unsigned CNT_W           = 16;

endpackage

// File: rtl/ccpd_sr_responder_if.sv
// ccpd_sr_responder_if: CCPD configuration serial bus.
//   SCLK - serial clock (master -> chip)
//   SDI  - serial data  (master -> chip)
//   SEN  - transfer enable, active-high (master -> chip)
//   SLD  - load strobe, active-high (master -> chip)
//   SDO  - serial data  (chip -> master)
// Modports: master (drives SCLK/SDI/SEN/SLD), slave (drives SDO).
interface ccpd_sr_responder_if;

   logic SCLK;
   logic SDI;
   logic SEN;
   logic SLD;
   logic SDO;

   modport master (output SCLK, output SDI, output SEN, output SLD, input SDO);
   modport slave  (input SCLK, input SDI, input SEN, input SLD, output SDO);

endinterface

// File: rtl/ccpd_sr_responder_sync_edge.sv
// sync_edge: 2-FF synchronizer followed by a registered edge detector.
//   clk  - sampling clock
//   rst  - synchronous active-high reset
//   din  - asynchronous input
//   lvl  - synchronized level, aligned with rise/fall
//   rise - one-cycle pulse on a 0->1 transition of the synchronized input
//   fall - one-cycle pulse on a 1->0 transition of the synchronized input
// An edge on din shows up on rise/fall (and lvl) three clk cycles later.
module sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= RST_VAL;
         s2   <= RST_VAL;
         lvl  <= RST_VAL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         lvl  <= s2;
         rise <= s2 & ~lvl;
         fall <= ~s2 & lvl;
      end
   end

endmodule

// File: rtl/ccpd_sr_responder.sv
// ccpd_sr_responder: chip-side stand-in for the CCPD configuration shift
// register. Oversamples the serial bus in the BUS_CLK domain, shifts SDI into
// an SR_BITS register on SCLK rises while SEN is high, returns the register
// MSB on SDO and copies the register to CONF on an SLD rise outside a frame.
//   BUS_CLK    - sole clock
//   BUS_RST    - synchronous active-high reset
//   bus        - serial bus, slave side (SCLK/SDI/SEN/SLD in, SDO out)
//   CONF       - latched configuration word
//   CONF_VALID - one-cycle pulse when CONF updates
//   BIT_CNT    - bits shifted in the current or last frame
//   LEN_ERR    - last frame length differed from SR_BITS
// Build option: define CCPD_SR_RESP_BITCNT_EN to include the frame bit
// counter and length check; otherwise BIT_CNT and LEN_ERR are tied to 0.
module ccpd_sr_responder
   import ccpd_sr_pkg::*;
#(
   parameter int unsigned SR_BITS = SR_BITS_DEFAULT
) (
   input  logic               BUS_CLK,
   input  logic               BUS_RST,
   ccpd_sr_responder_if.slave bus,
   output logic [SR_BITS-1:0] CONF,
   output logic               CONF_VALID,
   output logic [CNT_W-1:0]   BIT_CNT,
   output logic               LEN_ERR
);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic sen_lvl,  sen_rise,  sen_fall;
   logic sld_lvl,  sld_rise,  sld_fall;
   logic sdi_s1, sdi_s2;
   logic [SR_BITS-1:0] sr;
   logic sdo_q;
   logic shift_en;
   logic load_go;
   state_t state_q, state_d;

   sync_edge #(.RST_VAL(1'b0)) u_sclk (
      .clk (BUS_CLK), .rst (BUS_RST), .din (bus.SCLK),
      .lvl (sclk_lvl), .rise (sclk_rise), .fall (sclk_fall)
   );

   sync_edge #(.RST_VAL(1'b0)) u_sen (
      .clk (BUS_CLK), .rst (BUS_RST), .din (bus.SEN),
      .lvl (sen_lvl), .rise (sen_rise), .fall (sen_fall)
   );

   sync_edge #(.RST_VAL(1'b0)) u_sld (
      .clk (BUS_CLK), .rst (BUS_RST), .din (bus.SLD),
      .lvl (sld_lvl), .rise (sld_rise), .fall (sld_fall)
   );

   // Edge-detector outputs that have no consumer in this block.
   logic unused_edges;
   assign unused_edges = ^{sclk_lvl, sclk_fall, sld_lvl, sld_fall};

   // SDI only needs a plain synchronizer: the master changes it half an
   // SCLK period before the rise, so it is long settled when the rise lands.
   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         sdi_s1 <= 1'b0;
         sdi_s2 <= 1'b0;
      end else begin
         sdi_s1 <= bus.SDI;
         sdi_s2 <= sdi_s1;
      end
   end

   // sen_lvl is aligned with the edge pulses, so a SEN rise coinciding with
   // an SCLK rise shifts that bit and a coinciding SEN fall does not.
   assign shift_en = sclk_rise & sen_lvl;

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         sr    <= '0;
         sdo_q <= 1'b0;
      end else begin
         if (shift_en) begin
            sr <= {sr[SR_BITS-2:0], sdi_s2};
         end
         sdo_q <= sr[SR_BITS-1];
      end
   end

   assign bus.SDO = sdo_q;

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // load_go marks the IDLE->LOAD transition; CONF is captured on that edge
   // so CONF_VALID is high exactly during the LOAD cycle.
   always_comb begin
      state_d = state_q;
      load_go = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sen_rise) begin
               state_d = SHIFT;
            end else if (sld_rise && !sen_lvl) begin
               state_d = LOAD;
               load_go = 1'b1;
            end
         end
         SHIFT: begin
            if (sen_fall) begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         CONF       <= '0;
         CONF_VALID <= 1'b0;
      end else begin
         CONF_VALID <= load_go;
         if (load_go) begin
            CONF <= sr;
         end
      end
   end

`ifdef CCPD_SR_RESP_BITCNT_EN
   logic [CNT_W-1:0] cnt;
   logic             len_err;

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         cnt     <= '0;
         len_err <= 1'b0;
      end else begin
         if (sen_rise) begin
            cnt <= {{(CNT_W-1){1'b0}}, shift_en};
         end else if (shift_en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
         end
         if (sen_rise) begin
            len_err <= 1'b0;
         end else if (sen_fall) begin
            len_err <= (32'(cnt) != 32'(SR_BITS));
         end
      end
   end

   assign BIT_CNT = cnt;
   assign LEN_ERR = len_err;
`else
   assign BIT_CNT = '0;
   assign LEN_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ccpd_sr_responder.sv
// tb_ccpd_sr_responder: directed + randomized bench for ccpd_sr_responder
// with SR_BITS=16, a 20 ns BUS_CLK and a 48-cycle SCLK period. The expected
// register contents are kept as a bit queue (oldest bit = MSB).
module tb_ccpd_sr_responder;

   localparam int unsigned N    = 16;
   localparam int          HALF = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   ccpd_sr_responder_if bus ();

   logic [N-1:0] conf;
   logic         conf_valid;
   logic [15:0]  bit_cnt;
   logic         len_err;

   ccpd_sr_responder #(.SR_BITS(N)) dut (
      .BUS_CLK    (clk),
      .BUS_RST    (rst),
      .bus        (bus),
      .CONF       (conf),
      .CONF_VALID (conf_valid),
      .BIT_CNT    (bit_cnt),
      .LEN_ERR    (len_err)
   );

   int total = 0;
   int bad   = 0;

   bit           msr[$];
   int           mcnt;
   logic         mlen;
   logic [N-1:0] mconf;

   function automatic logic [N-1:0] model_word();
      logic [N-1:0] w;
      w = '0;
      for (int i = 0; i < int'(N); i++) w[N-1-i] = msr[i];
      return w;
   endfunction

   function automatic int exp_cnt();
`ifdef CCPD_SR_RESP_BITCNT_EN
      return mcnt;
`else
      return 0;
`endif
   endfunction

   function automatic logic exp_len();
`ifdef CCPD_SR_RESP_BITCNT_EN
      return mlen;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_clear();
      msr.delete();
      for (int i = 0; i < int'(N); i++) msr.push_back(1'b0);
      mcnt  = 0;
      mlen  = 1'b0;
      mconf = '0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sen_start();
      bus.SEN = 1'b1;
      mcnt = 0;
      mlen = 1'b0;
      tick(8);
      check("cnt_at_start", 32'(bit_cnt), 32'(exp_cnt()));
      check("len_at_start", 32'(len_err), 32'(exp_len()));
   endtask

   task automatic clock_bit(input bit b);
      bus.SDI = b;
      tick(HALF);
      check("sdo", 32'(bus.SDO), 32'(msr[0]));
      bus.SCLK = 1'b1;
      msr.push_back(b);
      void'(msr.pop_front());
      if (mcnt < 65535) mcnt++;
      tick(HALF);
      bus.SCLK = 1'b0;
   endtask

   task automatic sen_end();
      tick(HALF);
      bus.SEN = 1'b0;
      mlen = (mcnt != int'(N));
      tick(8);
      check("cnt_at_end", 32'(bit_cnt), 32'(exp_cnt()));
      check("len_at_end", 32'(len_err), 32'(exp_len()));
   endtask

   task automatic frame(input int nbits, input logic [31:0] data);
      sen_start();
      for (int i = 0; i < nbits; i++) clock_bit(data[nbits-1-i]);
      sen_end();
   endtask

   task automatic load(input bit sen_high);
      int pulses;
      pulses = 0;
      bus.SLD = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick(1);
         if (conf_valid === 1'b1) pulses++;
         if (i == 5) bus.SLD = 1'b0;
      end
      if (!sen_high) mconf = model_word();
      check("cv_pulses", 32'(pulses), sen_high ? 32'd0 : 32'd1);
      check("conf", 32'(conf), 32'(mconf));
   endtask

   initial begin
      bus.SCLK = 1'b0;
      bus.SDI  = 1'b0;
      bus.SEN  = 1'b0;
      bus.SLD  = 1'b0;
      model_clear();

      // Reset state
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      check("rst_conf", 32'(conf), 32'd0);
      check("rst_cv", 32'(conf_valid), 32'd0);
      check("rst_cnt", 32'(bit_cnt), 32'd0);
      check("rst_len", 32'(len_err), 32'd0);
      check("rst_sdo", 32'(bus.SDO), 32'd0);
      tick(4);

      // Shift then load
      frame(16, 32'hA5C3);
      load(1'b0);

      // Loopback: SDO stream returns A5C3, then CONF reads zero twice
      frame(16, 32'h0000);
      load(1'b0);
      load(1'b0);

      // Short frame, then a full frame clears the length error
      frame(15, 32'($urandom_range(0, 32767)));
      load(1'b0);
      frame(16, 32'($urandom_range(0, 65535)));
      load(1'b0);

      // SLD while SEN is high is ignored
      sen_start();
      load(1'b1);
      sen_end();

      // Random frame lengths and data
      for (int k = 0; k < 4; k++) begin
         frame(int'($urandom_range(1, 20)), $urandom);
         load(1'b0);
      end

      // Reset mid-frame with SEN held high
      sen_start();
      for (int i = 0; i < 8; i++) clock_bit(1'($urandom));
      rst = 1'b1;
      tick(2);
      model_clear();
      check("mid_rst_conf", 32'(conf), 32'd0);
      check("mid_rst_cv", 32'(conf_valid), 32'd0);
      check("mid_rst_cnt", 32'(bit_cnt), 32'd0);
      check("mid_rst_len", 32'(len_err), 32'd0);
      check("mid_rst_sdo", 32'(bus.SDO), 32'd0);
      rst = 1'b0;
      tick(8);
      check("post_rst_cnt", 32'(bit_cnt), 32'd0);
      begin
         logic [15:0] d;
         d = 16'($urandom);
         for (int i = 0; i < 16; i++) clock_bit(d[15-i]);
      end
      sen_end();
      load(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
